// File: rtl/decode_stage.sv
// decode_stage: instruction decode with an 8x16 register file and the ID/EX
// pipeline register.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   freeze              1 = pipeline advances, 0 = ID/EX holds (the register
//                       file still accepts writes)
//   instr_IFID, PC2_IFID, halt_IFID   IF/ID inputs
//   takeBranch_EXMEM    flush request; turns the next ID/EX load into a bubble
//   wb_we, wb_rd, wb_data             register-file write port
//   stallCtrl           combinational load-use stall back to fetch
//   *_IDEX              registered decode results
//
// Parameter NOP_INSTR is the instruction word placed in ID/EX for a bubble
// and on reset.
//
// Build option: define DECODE_BYPASS_EN to make a same-cycle writeback to a
// register being read visible on that read port (write-through). Without
// it, the read returns the value held before the write.
module decode_stage #(
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic [15:0] instr_IFID,
  input  logic [15:0] PC2_IFID,
  input  logic        halt_IFID,
  input  logic        takeBranch_EXMEM,
  input  logic        wb_we,
  input  logic [2:0]  wb_rd,
  input  logic [15:0] wb_data,
  output logic        stallCtrl,
  output logic [15:0] regA_IDEX,
  output logic [15:0] regB_IDEX,
  output logic [15:0] imm_IDEX,
  output logic [15:0] PC2_IDEX,
  output logic [15:0] instr_IDEX,
  output logic [2:0]  rd_IDEX,
  output logic        regWrite_IDEX,
  output logic        memRead_IDEX,
  output logic        memWrite_IDEX,
  output logic        halt_IDEX,
  output logic        err_IDEX
);

  // field decode
  logic [4:0]  opc;
  logic [2:0]  rs, rt, rd_dec;
  logic [15:0] imm_dec;
  logic        is_load, is_store, no_wr, reg_write_dec, err_dec, i_fmt1;

  assign opc    = instr_IFID[15:11];
  assign rs     = instr_IFID[10:8];
  assign rt     = instr_IFID[7:5];
  assign rd_dec = (opc == 5'b11011) ? instr_IFID[4:2] : instr_IFID[7:5];

  // jumps (001xx) carry an 11-bit displacement, everything else 5 bits
  assign imm_dec = (opc[4:2] == 3'b001) ? {{5{instr_IFID[10]}}, instr_IFID[10:0]}
                                        : {{11{instr_IFID[4]}}, instr_IFID[4:0]};

  assign is_load       = (opc == 5'b10001);
  assign is_store      = (opc == 5'b10000);
  assign no_wr         = (opc == 5'b00000) || (opc == 5'b00001) ||
                         (opc[4:2] == 3'b001) || (opc[4:2] == 3'b011);
  assign reg_write_dec = !no_wr && !is_store;
  assign err_dec       = (opc == 5'b00010);

  // Immediate-ALU ops (010xx, 101xx) and load use [7:5] as their
  // destination, so it is not a source for the load-use check. Stores keep
  // the rt compare because [7:5] is the data being stored.
  assign i_fmt1 = (opc[4:2] == 3'b010) || (opc[4:2] == 3'b101) || is_load;

  // register file
  logic [15:0] rf [8];
  logic [15:0] rd_a, rd_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (wb_we) begin
      rf[wb_rd] <= wb_data;
    end
  end

`ifdef DECODE_BYPASS_EN
  assign rd_a = (wb_we && wb_rd == rs) ? wb_data : rf[rs];
  assign rd_b = (wb_we && wb_rd == rt) ? wb_data : rf[rt];
`else
  assign rd_a = rf[rs];
  assign rd_b = rf[rt];
`endif

  // hazard / flush
  logic bubble;

  // Only a load sets memRead_IDEX, so bubbles and HALT never stall.
  // A flush cancels the stall: the instruction would be discarded anyway.
  assign stallCtrl = !rst && memRead_IDEX && !takeBranch_EXMEM &&
                     ((rd_IDEX == rs) || (!i_fmt1 && rd_IDEX == rt));
  assign bubble    = stallCtrl || takeBranch_EXMEM;

  // ID/EX register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regA_IDEX     <= '0;
      regB_IDEX     <= '0;
      imm_IDEX      <= '0;
      PC2_IDEX      <= '0;
      instr_IDEX    <= NOP_INSTR;
      rd_IDEX       <= '0;
      regWrite_IDEX <= 1'b0;
      memRead_IDEX  <= 1'b0;
      memWrite_IDEX <= 1'b0;
      halt_IDEX     <= 1'b0;
      err_IDEX      <= 1'b0;
    end else if (freeze) begin
      if (bubble) begin
        regA_IDEX     <= '0;
        regB_IDEX     <= '0;
        imm_IDEX      <= '0;
        PC2_IDEX      <= '0;
        instr_IDEX    <= NOP_INSTR;
        rd_IDEX       <= '0;
        regWrite_IDEX <= 1'b0;
        memRead_IDEX  <= 1'b0;
        memWrite_IDEX <= 1'b0;
        halt_IDEX     <= 1'b0;
        err_IDEX      <= 1'b0;
      end else begin
        regA_IDEX     <= rd_a;
        regB_IDEX     <= rd_b;
        imm_IDEX      <= imm_dec;
        PC2_IDEX      <= PC2_IFID;
        instr_IDEX    <= instr_IFID;
        rd_IDEX       <= rd_dec;
        regWrite_IDEX <= reg_write_dec;
        memRead_IDEX  <= is_load;
        memWrite_IDEX <= is_store;
        halt_IDEX     <= halt_IFID;
        err_IDEX      <= err_dec;
      end
    end
  end

endmodule
